mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the five-stage RV64 pipeline. It consumes the execute-stage bundle (`excute_data_t`), performs doubleword loads and stores over the data bus with a valid/ok handshake, and hands a write-back bundle to the write-back stage. It stalls execute through `in_ready` while a bus transaction is outstanding or its output register is blocked.

## Interface

Parameters:
- `DBUS_SIZE`, default `MSIZE8`: access size driven on every request; only LD/SD are supported.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_valid` in 1: execute bundle present.
- `in_ready` out 1: bundle accepted this cycle when `in_valid & in_ready`.
- `in_data` in `excute_data_t` (135): result/address, wdata, memwrite, dst, regwrite.
- `in_memread` in 1: bundle is a load; never set together with `memwrite`.
- `out_valid` out 1: write-back bundle valid.
- `out_ready` in 1: write-back consumes when `out_valid & out_ready`.
- `out_data` out `wb_data_t` (70): `result` 64, `dst` 5, `regwrite` 1.
- `dreq` out `dbus_req_t`: `valid`, `addr` 64, `size` 3, `strobe` 8, `data` 64.
- `dresp` in `dbus_resp_t`: `addr_ok`, `data_ok`, `data` 64.

## Operation

- States:
  - `IDLE`: no bus transaction pending.
  - `BUS`: request outstanding.
- Output register `{out_valid, out_data}` is separate from the state.
- `in_ready = (state==IDLE) & (!out_valid | out_ready)`.
- Accepting a non-memory bundle (`!memwrite & !in_memread`):
  - Next cycle: `out_valid=1`, `out_data={in.result, in.dst, in.regwrite}`.
  - State stays `IDLE`.
- Accepting a load or store:
  - Latch the bundle; go to `BUS`.
  - If the output register is not being refilled in the same cycle, `out_valid` drops to 0.
- While in `BUS`, `dreq` is driven as follows:
  - `valid=1`, `addr=latched result` (unmodified), `size=DBUS_SIZE`.
  - Store: `strobe=8'hFF`, `data=wdata`.
  - Load: `strobe=8'h00`, `data=0`.
- `dreq.valid` and all request fields are held constant until `dresp.data_ok`, regardless of `addr_ok`.
- On `data_ok` in `BUS`:
  - Next cycle: `state=IDLE`, `out_valid=1`.
  - Load: `out_data.result=dresp.data`.
  - Store: `out_data.result` = latched address, `regwrite` = latched value (0 for SD).
- `data_ok` while `IDLE` is ignored.
- Output register changes only when empty or consumed (`!out_valid | out_ready`). Otherwise it holds all fields stable.

## Timing

- Reset values:
  - `state=IDLE`, `out_valid=0`, `out_data=0`.
  - `dreq=0` (`valid=0`).
  - `in_ready` is 1 in the cycle after reset.
- Non-memory latency: 1 cycle, accept to `out_valid`. Full throughput of 1/cycle when `out_ready=1`.
- Memory latency: accept (cycle N), then `dreq.valid` from N+1. If `data_ok` arrives in cycle M ≥ N+1, then `out_valid` is set in M+1.
  - Minimum is 2 cycles.
  - `in_ready=0` from N+1 through M.
- Simultaneous consume and accept in one cycle: `out_ready` drains the old bundle and `in_valid` loads the new one. No bubble.
- `out_ready=0` with `out_valid=1`: `in_ready=0`, and the pipeline backs up.
- A load result is never written over an unconsumed output.
- Reset mid-transaction (`BUS`):
  - `dreq.valid=0` next cycle, state `IDLE`.
  - Latched bundle and output are discarded.
  - The data bus is reset in the same cycle, so no stale `data_ok` is consumed.
- `addr` alignment is not checked; `addr[2:0]` passes through to the bus.

## Structure

- Shared `pipes` package additions:
  - `wb_data_t` (`result`, `dst`, `regwrite`).
  - `mem_state_t` enum (`IDLE`, `BUS`).
- `dbus_req_t`, `dbus_resp_t`, `MSIZE8`, `word_t`, `creg_addr_t` come from `common`.
- One sub-module is natural: `dbus_req_gen`. It is combinational and builds `dreq` from the latched bundle plus state.
- Everything else is a single flat module.

## Test plan

- Non-memory stream:
  - Stimulus: 3 back-to-back ADD bundles with `result` `0x10`, `0x20`, `0x30`, `dst` 5, 6, 7, `regwrite=1`, and `out_ready=1`.
  - Required: `out_valid` in cycles 1-3 with matching data, and `in_ready` constant 1.
- Load, delayed bus:
  - Stimulus: LD with `addr=0x8000_0040`; `addr_ok` at +2, `data_ok` at +4 with data `0xDEAD_BEEF_0000_0001`.
  - Required: `dreq` stable for 4 cycles, `out_data.result=0xDEAD_BEEF_0000_0001` one cycle after `data_ok`, and `in_ready=0` throughout.
- Store:
  - Stimulus: SD with `addr=0x100`, `wdata=0x55`, and `data_ok` on the first cycle.
  - Required: `strobe=0xFF`, `dreq.data=0x55`, then `out_valid` with `regwrite=0` 2 cycles after accept.
- Back-pressure:
  - Stimulus: `out_ready=0` for 5 cycles with `out_valid=1`, then a pending LD upstream.
  - Required: `in_ready=0` and `out_data` unchanged for those 5 cycles; LD accepted in the cycle `out_ready` rises.
- Reset mid-LD:
  - Stimulus: assert `reset` 2 cycles into `BUS`.
  - Required: next cycle `dreq.valid=0`, `out_valid=0`, `in_ready=1`. A later `data_ok` produces no output.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Types shared by the memory-access stage: data-bus request/response, the
// execute and write-back bundles, and the stage FSM encoding.
package mem_access_pkg;
    typedef logic [63:0] word_t;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [2:0]  msize_t;
    typedef logic [7:0]  strobe_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    typedef struct packed {
        logic    valid;
        word_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        word_t      result;
        word_t      wdata;
        logic       memwrite;
        creg_addr_t dst;
        logic       regwrite;
    } excute_data_t;

    typedef struct packed {
        word_t      result;
        creg_addr_t dst;
        logic       regwrite;
    } wb_data_t;

    typedef logic [0:0] mem_state_t;
    localparam mem_state_t IDLE = 1'b0;
    localparam mem_state_t BUS  = 1'b1;

    function automatic wb_data_t to_wb(word_t result, creg_addr_t dst, logic regwrite);
        wb_data_t w;
        w.result   = result;
        w.dst      = dst;
        w.regwrite = regwrite;
        return w;
    endfunction
endpackage

// File: rtl/mem_access_dbus_req_gen.sv
// Combinational data-bus request builder; the request is a pure function of
// the latched bundle and state, so it stays constant for the whole transaction.
module dbus_req_gen
    import mem_access_pkg::*;
#(
    parameter msize_t DBUS_SIZE = MSIZE8
) (
    input  mem_state_t state,
    input  word_t      addr,
    input  word_t      wdata,
    input  logic       is_store,
    output dbus_req_t  dreq
);
    always_comb begin
        dreq = '0;
        if (state == BUS) begin
            dreq.valid = 1'b1;
            dreq.addr  = addr;
            dreq.size  = DBUS_SIZE;
            if (is_store) begin
                dreq.strobe = 8'hFF;
                dreq.data   = wdata;
            end
        end
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results through in one cycle and performs
// doubleword loads/stores over a valid/data_ok bus, stalling execute meanwhile.
module mem_access
    import mem_access_pkg::*;
#(
    parameter msize_t DBUS_SIZE = MSIZE8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  excute_data_t in_data,
    input  logic         in_memread,
    output logic         out_valid,
    input  logic         out_ready,
    output wb_data_t     out_data,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp
);
    mem_state_t   state;
    excute_data_t lat;
    logic         out_free;
    logic         accept;
    logic         is_mem;
    logic         unused_addr_ok;

    // Requests are held until data_ok, so addr_ok carries no information here.
    assign unused_addr_ok = dresp.addr_ok;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_data.memwrite || in_memread;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_free)
                out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (is_mem) begin
                        state <= BUS;
                        lat   <= in_data;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= to_wb(in_data.result, in_data.dst, in_data.regwrite);
                    end
                end
            end else if (dresp.data_ok && out_free) begin
                // Stores report their address as the result, loads the bus data.
                state     <= IDLE;
                out_valid <= 1'b1;
                out_data  <= to_wb(lat.memwrite ? lat.result : dresp.data, lat.dst, lat.regwrite);
            end
        end
    end

    dbus_req_gen #(.DBUS_SIZE(DBUS_SIZE)) u_req_gen (
        .state    (state),
        .addr     (lat.result),
        .wdata    (lat.wdata),
        .is_store (lat.memwrite),
        .dreq     (dreq)
    );
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a write-back scoreboard.
module tb_mem_access;
    import mem_access_pkg::*;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    excute_data_t in_data;
    logic         in_memread;
    logic         out_valid;
    logic         out_ready;
    wb_data_t     out_data;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;

    int checks   = 0;
    int failures = 0;
    wb_data_t exp_q[$];
    wb_data_t e;
    dbus_req_t exp_req;
    wb_data_t held;

    mem_access #(.DBUS_SIZE(MSIZE8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_memread (in_memread),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .dreq       (dreq),
        .dresp      (dresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic excute_data_t mk(word_t result, word_t wdata, logic mw, creg_addr_t dst, logic rw);
        excute_data_t d;
        d.result   = result;
        d.wdata    = wdata;
        d.memwrite = mw;
        d.dst      = dst;
        d.regwrite = rw;
        return d;
    endfunction

    // Scoreboard: every write-back handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("wb_expected", 160'(exp_q.size() > 0), 160'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_data", 160'(out_data), 160'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_memread = 1'b0;
        out_ready = 1'b1; dresp = '0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  160'(in_ready),  160'(1));
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_out_data",  160'(out_data),  160'(0));
        chk("rst_dreq",      160'(dreq),      160'(0));
        tick();

        // Non-memory stream, full throughput
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_valid = 1'b1; in_memread = 1'b0;
                in_data = mk(64'(64'h10 * (i + 1)), 64'h0, 1'b0, 5'(5 + i), 1'b1);
                exp_q.push_back(to_wb(64'(64'h10 * (i + 1)), 5'(5 + i), 1'b1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("nm_in_ready", 160'(in_ready), 160'(1));
            if (i > 0) chk("nm_out_valid", 160'(out_valid), 160'(1));
            tick();
        end
        @(negedge clk);
        chk("nm_drained", 160'(out_valid), 160'(0));
        tick();

        // Load with addr_ok at +2 and data_ok at +4
        in_valid = 1'b1; in_memread = 1'b1;
        in_data = mk(64'h8000_0040, 64'h0, 1'b0, 5'd9, 1'b1);
        exp_q.push_back(to_wb(64'hDEAD_BEEF_0000_0001, 5'd9, 1'b1));
        @(negedge clk);
        chk("ld_accept", 160'(in_ready), 160'(1));
        tick();
        in_valid = 1'b0; in_memread = 1'b0;
        exp_req = '0;
        exp_req.valid = 1'b1; exp_req.addr = 64'h8000_0040; exp_req.size = MSIZE8;
        for (int k = 1; k <= 4; k++) begin
            dresp.addr_ok = (k == 2);
            dresp.data_ok = (k == 4);
            dresp.data    = (k == 4) ? 64'hDEAD_BEEF_0000_0001 : 64'h0BAD;
            @(negedge clk);
            chk("ld_dreq",      160'(dreq),      160'(exp_req));
            chk("ld_in_ready",  160'(in_ready),  160'(0));
            chk("ld_out_valid", 160'(out_valid), 160'(0));
            tick();
        end
        dresp = '0;
        @(negedge clk);
        chk("ld_out_valid_done", 160'(out_valid), 160'(1));
        chk("ld_result", 160'(out_data.result), 160'(64'hDEAD_BEEF_0000_0001));
        tick();
        @(negedge clk);
        chk("ld_idle_ready", 160'(in_ready), 160'(1));
        tick();

        // Store with data_ok on first bus cycle
        in_valid = 1'b1; in_memread = 1'b0;
        in_data = mk(64'h100, 64'h55, 1'b1, 5'd0, 1'b0);
        exp_q.push_back(to_wb(64'h100, 5'd0, 1'b0));
        tick();
        in_valid = 1'b0;
        dresp.data_ok = 1'b1; dresp.data = 64'hFFFF;
        @(negedge clk);
        chk("sd_valid",  160'(dreq.valid),  160'(1));
        chk("sd_addr",   160'(dreq.addr),   160'(64'h100));
        chk("sd_strobe", 160'(dreq.strobe), 160'(8'hFF));
        chk("sd_data",   160'(dreq.data),   160'(64'h55));
        tick();
        dresp = '0;
        @(negedge clk);
        chk("sd_out_valid", 160'(out_valid),         160'(1));
        chk("sd_regwrite",  160'(out_data.regwrite), 160'(0));
        tick();

        // Back-pressure with a pending load upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_memread = 1'b0;
        in_data = mk(64'hAB, 64'h0, 1'b0, 5'd3, 1'b1);
        exp_q.push_back(to_wb(64'hAB, 5'd3, 1'b1));
        held = to_wb(64'hAB, 5'd3, 1'b1);
        tick();
        in_memread = 1'b1;
        in_data = mk(64'h200, 64'h0, 1'b0, 5'd4, 1'b1);
        exp_q.push_back(to_wb(64'h1234, 5'd4, 1'b1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 160'(out_valid), 160'(1));
            chk("bp_in_ready",  160'(in_ready),  160'(0));
            chk("bp_out_data",  160'(out_data),  160'(held));
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", 160'(in_ready), 160'(1));
        tick();
        in_valid = 1'b0; in_memread = 1'b0;
        dresp.data_ok = 1'b1; dresp.data = 64'h1234;
        @(negedge clk);
        chk("bp_ld_valid", 160'(dreq.valid), 160'(1));
        chk("bp_ld_addr",  160'(dreq.addr),  160'(64'h200));
        tick();
        dresp = '0;
        @(negedge clk);
        chk("bp_ld_out", 160'(out_valid), 160'(1));
        tick();

        // Reset two cycles into a load
        in_valid = 1'b1; in_memread = 1'b1;
        in_data = mk(64'h300, 64'h0, 1'b0, 5'd7, 1'b1);
        tick();
        in_valid = 1'b0; in_memread = 1'b0;
        @(negedge clk);
        chk("rl_bus", 160'(dreq.valid), 160'(1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rl_dreq_valid", 160'(dreq.valid), 160'(0));
        chk("rl_out_valid",  160'(out_valid),  160'(0));
        chk("rl_in_ready",   160'(in_ready),   160'(1));
        tick();
        dresp.data_ok = 1'b1; dresp.data = 64'h5A5A;
        tick();
        dresp = '0;
        @(negedge clk);
        chk("rl_no_output", 160'(out_valid), 160'(0));
        tick();

        chk("sb_empty", 160'(exp_q.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
